// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request/response handshakes plus the ALU drive and result lines.
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic [1:0]  rsp_err;
    logic [3:0]  alu_opcode;
    logic        alu_exec;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [63:0] alu_result;

    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready, alu_result,
        input  req_ready, rsp_valid, z_hi, z_lo, rsp_err, alu_opcode, alu_exec, alu_a, alu_b
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready, alu_result,
        output req_ready, rsp_valid, z_hi, z_lo, rsp_err, alu_opcode, alu_exec, alu_a, alu_b
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences one ALU op per request, holds exec for a fixed settle time, returns the 64-bit result.
// Define ALU_SEQ_B2B_EN to let a new request be accepted on the same edge the pending response retires.
module alu_op_sequencer #(
    parameter int SHORT_LAT = 1,
    parameter int LONG_LAT  = 4
) (
    input logic               clk,
    input logic               clr,
    alu_op_sequencer_if.slave bus
);
`ifdef ALU_SEQ_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif
    localparam int MAXL = LONG_LAT > SHORT_LAT ? LONG_LAT : SHORT_LAT;
    localparam int CW   = MAXL > 1 ? $clog2(MAXL) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          long_op;
    logic          illegal;

    assign bus.req_ready = state == IDLE || (B2B && state == RESP && bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign long_op       = bus.req_opcode == 4'hB || bus.req_opcode == 4'hC;
    assign illegal       = bus.req_opcode > 4'hC;

    // Later assignments win, so an accept in RESP overrides the retire back to IDLE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.alu_opcode <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_exec   <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.z_hi       <= '0;
            bus.z_lo       <= '0;
            bus.rsp_err    <= '0;
        end else begin
            if (state == EXEC) begin
                if (cnt == '0) begin
                    bus.z_hi      <= bus.alu_result[63:32];
                    bus.z_lo      <= bus.alu_result[31:0];
                    bus.rsp_err   <= {bus.alu_opcode == 4'hC && bus.alu_b == '0, 1'b0};
                    bus.alu_exec  <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (state == RESP && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
                state         <= IDLE;
            end
            if (accept) begin
                bus.alu_opcode <= bus.req_opcode;
                bus.alu_a      <= bus.req_a;
                bus.alu_b      <= bus.req_b;
                cnt            <= long_op ? CW'(LONG_LAT - 1) : CW'(SHORT_LAT - 1);
                if (illegal) begin
                    bus.z_hi      <= '0;
                    bus.z_lo      <= '0;
                    bus.rsp_err   <= 2'b01;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end else begin
                    bus.alu_exec <= 1'b1;
                    state        <= EXEC;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table vectors, random ops against a reference model, and multi-cycle corner sequences.
module tb_alu_op_sequencer;
`ifdef ALU_SEQ_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif
    localparam int SL = 1;
    localparam int LL = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   npass = 0;
    int   ntot = 0;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.SHORT_LAT(SL), .LONG_LAT(LL)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] t;
        logic [4:0]  s;
        s = b[4:0];
        case (op)
            4'h0: return {32'h0, a + b};
            4'h1: return {32'h0, a - b};
            4'h2: return {32'h0, a & b};
            4'h3: return {32'h0, a | b};
            4'h4: return {32'h0, -a};
            4'h5: return {32'h0, ~a};
            4'h6: return {32'h0, a >> s};
            4'h7: return {32'h0, 32'($signed(a) >>> s)};
            4'h8: return {32'h0, a << s};
            4'h9: begin t = {a, a} >> s; return {32'h0, t[31:0]}; end
            4'hA: begin t = {a, a} << s; return {32'h0, t[63:32]}; end
            4'hB: return {32'h0, a} * {32'h0, b};
            4'hC: return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: return 64'h0;
        endcase
    endfunction

    always_comb bus.alu_result = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", n, got, exp);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rr,
                          output int lat, output int ex, output logic [63:0] z, output logic [1:0] err);
        wait_idle();
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.rsp_ready  = rr;
        @(posedge clk);
        lat = -1;
        ex  = 0;
        z   = '0;
        err = '0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            ex += int'(bus.alu_exec);
            if (bus.rsp_valid) begin
                lat = i;
                z   = {bus.z_hi, bus.z_lo};
                err = bus.rsp_err;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          ex;
        logic [63:0] z;
        logic [1:0]  err;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[8];
        int          lat;
        int          ex;
        int          k;
        logic [63:0] z;
        logic [1:0]  err;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ok;
        vecs[0] = '{4'h0, 32'd5, 32'd7, 2, 1, 64'd12, 2'b00};
        vecs[1] = '{4'hB, 32'h0001_0000, 32'h0001_0000, 5, 4, 64'h0000_0001_0000_0000, 2'b00};
        vecs[2] = '{4'hC, 32'd17, 32'd5, 5, 4, {32'd2, 32'd3}, 2'b00};
        vecs[3] = '{4'hC, 32'd9, 32'd0, 5, 4, {32'd9, 32'hFFFF_FFFF}, 2'b10};
        vecs[4] = '{4'hF, 32'd1, 32'd2, 1, 0, 64'd0, 2'b01};
        vecs[5] = '{4'h1, 32'd10, 32'd3, 2, 1, 64'd7, 2'b00};
        vecs[6] = '{4'h8, 32'd1, 32'd4, 2, 1, 64'd16, 2'b00};
        vecs[7] = '{4'h9, 32'd1, 32'd1, 2, 1, 64'h8000_0000, 2'b00};

        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {bus.alu_exec, bus.rsp_valid, bus.rsp_err}, 0);
        chk("rst_z", {bus.z_hi, bus.z_lo}, 0);
        chk("rst_alu", {bus.alu_opcode, bus.alu_a, bus.alu_b}, 0);
        clr = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, lat, ex, z, err);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_exec", i), ex, vecs[i].ex);
            chk($sformatf("vec%0d_z", i), z, vecs[i].z);
            chk($sformatf("vec%0d_err", i), err, vecs[i].err);
        end

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
            run_op(op, a, b, 1'b1, lat, ex, z, err);
            chk($sformatf("rnd%0d_lat", i), lat, op > 12 ? 1 : (op >= 11 ? LL + 1 : SL + 1));
            chk($sformatf("rnd%0d_exec", i), ex, op > 12 ? 0 : (op >= 11 ? LL : SL));
            chk($sformatf("rnd%0d_z", i), z, op > 12 ? 64'd0 : alu_fn(op, a, b));
            chk($sformatf("rnd%0d_err", i), err, op > 12 ? 2'b01 : (op == 12 && b == 0 ? 2'b10 : 2'b00));
        end

        @(negedge clk);
        run_op(4'h1, 32'd10, 32'd3, 1'b0, lat, ex, z, err);
        chk("hold_lat", lat, 2);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            ok &= bus.rsp_valid && bus.z_lo == 32'd7 && bus.rsp_err == 2'b00 && !bus.req_ready;
        end
        chk("hold_stable", ok, 1);
        bus.rsp_ready = 1'b1;
        #1;
        chk("hold_ready_same_cycle", bus.req_ready, B2B);
        @(negedge clk);
        chk("hold_ready_after", bus.req_ready, 1);
        chk("hold_retired", bus.rsp_valid, 0);

        wait_idle();
        bus.req_valid  = 1'b1;
        bus.req_opcode = 4'hB;
        bus.req_a      = 32'd3;
        bus.req_b      = 32'd4;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("clr_exec_before", bus.alu_exec, 1);
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("clr_ctl", {bus.alu_exec, bus.rsp_valid, bus.rsp_err}, 0);
        chk("clr_z", {bus.z_hi, bus.z_lo}, 0);
        chk("clr_alu", {bus.alu_opcode, bus.alu_a, bus.alu_b}, 0);
        @(negedge clk);
        clr = 1'b0;
        ok  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            ok |= bus.rsp_valid;
        end
        chk("clr_no_rsp", ok, 0);
        run_op(4'h0, 32'd1, 32'd1, 1'b1, lat, ex, z, err);
        chk("clr_after_add", z, 64'd2);

        @(negedge clk);
        wait_idle();
        bus.req_valid  = 1'b1;
        bus.req_opcode = 4'h0;
        bus.req_a      = 32'd2;
        bus.req_b      = 32'd3;
        bus.rsp_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_a = 32'd4;
        bus.req_b = 32'd4;
        chk("b2b_first_exec", bus.alu_exec, 1);
        @(negedge clk);
        chk("b2b_first_rsp", {bus.rsp_valid, bus.z_lo}, {1'b1, 32'd5});
        @(negedge clk);
        chk("b2b_second_accept", bus.alu_exec, B2B);
        k = 0;
        while (!bus.rsp_valid && k < 10) begin
            if (bus.alu_exec) bus.req_valid = 1'b0;
            @(negedge clk);
            k++;
        end
        bus.req_valid = 1'b0;
        chk("b2b_second_rsp", {bus.rsp_valid, bus.z_lo}, {1'b1, 32'd8});
        @(negedge clk);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
